// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result handshake bundle for seq_divider.
// master drives operands and consumes results; slave is the divider side.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Handshake rule: a transfer happens on a rising clk edge where valid
    // and ready are both high; valid may not depend on ready, and the
    // payload must be stable while valid is high and ready is low.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock.
// IDLE accepts operands, RUN iterates WIDTH times (or one cycle for a zero
// divisor), DONE holds the registered result until the consumer takes it.
// Optional build macro DIV_SIGNED_EN: two's-complement operands/results,
// truncating toward zero; the sign fix is applied on the final-iteration load.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  div_if,
    output logic [1:0]    state_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [WIDTH-1:0] p_q, p_d;           // partial remainder; always < divisor, so its top bit is implicit 0
    logic [WIDTH-1:0] qs_q, qs_d;         // quotient shift register
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             neg_q_q, neg_q_d;   // negate quotient on completion
    logic             neg_r_q, neg_r_d;   // negate remainder on completion
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Operand magnitudes and signs as seen at the accept edge.
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             dvd_neg, dvs_neg;
`ifdef DIV_SIGNED_EN
    assign dvd_neg = div_if.dividend[WIDTH-1];
    assign dvs_neg = div_if.divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -div_if.dividend : div_if.dividend;
    assign dvs_mag = dvs_neg ? -div_if.divisor  : div_if.divisor;
`else
    assign dvd_neg = 1'b0;
    assign dvs_neg = 1'b0;
    assign dvd_mag = div_if.dividend;
    assign dvs_mag = div_if.divisor;
`endif

    // One restoring step: the WIDTH+1-bit shifted remainder minus the divisor.
    logic [WIDTH:0]   p_shift, trial;
    logic             q_bit;
    logic [WIDTH-1:0] p_next, qs_next, quo_fix, rem_fix, zero_rem;

    assign p_shift  = {p_q, dvd_q[WIDTH-1]};
    assign trial    = p_shift - {1'b0, dvs_q};
    assign q_bit    = ~trial[WIDTH];
    assign p_next   = q_bit ? trial[WIDTH-1:0] : p_shift[WIDTH-1:0];
    assign qs_next  = {qs_q[WIDTH-2:0], q_bit};
    assign quo_fix  = neg_q_q ? -qs_next : qs_next;
    assign rem_fix  = neg_r_q ? -p_next  : p_next;
    assign zero_rem = neg_r_q ? -dvd_q   : dvd_q;

    // Next-state and datapath: hold everything unless the state says otherwise.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        qs_d    = qs_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (div_if.in_valid) begin
                    dvd_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    p_d     = '0;
                    qs_d    = '0;
                    cnt_d   = '0;
                    zero_d  = (div_if.divisor == '0);
                    neg_q_d = dvd_neg ^ dvs_neg;
                    neg_r_d = dvd_neg;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (zero_q) begin
                    quo_d   = '1;
                    rem_d   = zero_rem;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    p_d   = p_next;
                    qs_d  = qs_next;
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        quo_d   = quo_fix;
                        rem_d   = rem_fix;
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (div_if.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            qs_q    <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            qs_q    <= qs_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign div_if.in_ready    = (state_q == IDLE);
    assign div_if.out_valid   = (state_q == DONE);
    assign div_if.quotient    = quo_q;
    assign div_if.remainder   = rem_q;
    assign div_if.div_by_zero = dbz_q;
    assign state_o            = state_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors for seq_divider (WIDTH = 8). A driver
// issues operands and pushes the hand-computed result into exp_q; a monitor
// pops and compares on every output handshake. Signed vectors only run
// when DIV_SIGNED_EN is defined; the unsigned vectors hold in both builds.
module tb_seq_divider;
    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] state;

    seq_divider_if #(.WIDTH(W)) dif ();

    seq_divider #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .div_if  (dif),
        .state_o (state)
    );

    int checks   = 0;
    int failures = 0;
    logic [2*W:0] exp_q[$];       // {div_by_zero, quotient, remainder}
    time accept_t;

    // Clock and reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: wait for in_ready, present operands for one accept edge.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
        int w = 0;
        while (!dif.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_wait", 32'(w < 50), 1);
        dif.dividend = a;
        dif.divisor  = b;
        dif.in_valid = 1'b1;
        @(posedge clk);
        accept_t = $time;
        exp_q.push_back({ez, eq, er});
        #1;
        dif.in_valid = 1'b0;
    endtask

    // Count edges from accept until out_valid; in_ready must stay low meanwhile.
    task automatic wait_result(input int exp_lat, input string name);
        int lat = 0;
        bit busy_ok = 1'b1;
        while (!dif.out_valid && lat < 30) begin
            if (dif.in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_in_ready_low"}, 32'(busy_ok), 1);
    endtask

    // Scoreboard monitor: compare every delivered result against exp_q.
    always @(negedge clk) begin
        if (rst_n && dif.out_valid && dif.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got q=%0h r=%0h expected none",
                         dif.quotient, dif.remainder);
            end else begin
                logic [2*W:0] e;
                e = exp_q.pop_front();
                check("quotient",    32'(dif.quotient),    32'(e[2*W-1:W]));
                check("remainder",   32'(dif.remainder),   32'(e[W-1:0]));
                check("div_by_zero", 32'(dif.div_by_zero), 32'(e[2*W]));
            end
        end
    end

    initial begin
        time t0;
        dif.in_valid  = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        dif.out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  32'(dif.in_ready),  1);
        check("rst_out_valid", 32'(dif.out_valid), 0);
        check("rst_quotient",  32'(dif.quotient),  0);
        check("rst_remainder", 32'(dif.remainder), 0);
        check("rst_dbz",       32'(dif.div_by_zero), 0);
        check("rst_state",     32'(state), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic division and zero divisor.
        start(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        wait_result(8, "d100_7");
        start(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
        wait_result(1, "d5_0");

        // Edge cases back-to-back with out_ready high: II must be 10 cycles.
        start(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        wait_result(8, "d255_1");
        t0 = accept_t;
        start(8'd3, 8'd200, 8'd0, 8'd3, 1'b0);
        check("ii_first", 32'(accept_t - t0), 100);
        wait_result(8, "d3_200");
        t0 = accept_t;
        start(8'd200, 8'd200, 8'd1, 8'd0, 1'b0);
        check("ii_second", 32'(accept_t - t0), 100);
        wait_result(8, "d200_200");
        @(posedge clk); #1;

        // Backpressure: held result, pulsed operands must be dropped.
        dif.out_ready = 1'b0;
        start(8'd90, 8'd7, 8'd12, 8'd6, 1'b0);
        wait_result(8, "d90_7");
        for (int i = 0; i < 5; i++) begin
            dif.dividend = 8'd9;
            dif.divisor  = 8'd2;
            dif.in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_in_ready",  32'(dif.in_ready),  0);
            check("bp_out_valid", 32'(dif.out_valid), 1);
            check("bp_quotient",  32'(dif.quotient),  12);
            check("bp_remainder", 32'(dif.remainder), 6);
        end
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(dif.in_ready), 1);
        start(8'd17, 8'd5, 8'd3, 8'd2, 1'b0);
        wait_result(8, "d17_5");
        @(posedge clk); #1;

        // Reset after 4 RUN iterations aborts the division.
        start(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(dif.out_valid), 0);
        check("abort_quotient",  32'(dif.quotient),  0);
        check("abort_remainder", 32'(dif.remainder), 0);
        check("abort_dbz",       32'(dif.div_by_zero), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 32'(dif.in_ready), 1);
        start(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        wait_result(8, "post_reset_100_7");

`ifdef DIV_SIGNED_EN
        start(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
        wait_result(8, "s_m100_7");
        start(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0);
        wait_result(8, "s_100_m7");
        start(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        wait_result(8, "s_m128_m1");
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider, the inverse of the adder-based shift-add multiply path: divides one WIDTH-bit dividend by one WIDTH-bit divisor, one quotient bit per clock. It sits after the accumulator to rescale and normalize accumulated sums, with valid/ready handshakes on both sides. One division is in flight at a time, and there is no input/output overlap.

## Interface
- WIDTH, 8, operand, quotient and remainder width; legal range is ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands; equals (state == IDLE).
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag: the divisor was 0.

## Operation
- States are IDLE, RUN and DONE; reset enters IDLE.
- IDLE
  - in_ready = 1.
  - When in_valid && in_ready on an edge: latch the operands and clear the iteration counter.
  - If divisor == 0, go to ZERO handling; otherwise go to RUN.
- ZERO handling (within the RUN slot)
  - On the next edge, load quotient = all ones, remainder = dividend, div_by_zero = 1.
  - Go to DONE.
- RUN: each edge performs one iteration.
  - The partial remainder P is WIDTH+1 bits.
  - P = {P[WIDTH-1:0], dividend_reg MSB}; shift dividend_reg left.
  - Compute the trial value T = P − {0, divisor}.
  - If T ≥ 0: P = T and shift 1 into the quotient register.
  - Otherwise: keep P and shift 0 into the quotient register.
  - After the WIDTH-th iteration, load quotient, remainder = P[WIDTH-1:0] and div_by_zero = 0, then go to DONE.
- DONE
  - out_valid = 1; quotient, remainder and div_by_zero are held stable.
  - When out_valid && out_ready on an edge: go to IDLE.
- in_valid is ignored outside IDLE; operands are not buffered.
- All arithmetic is unsigned modulo 2^(WIDTH+1) inside P, and results are exact: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Reset (async, takes effect immediately):
  - state = IDLE.
  - out_valid = 0; quotient, remainder and div_by_zero = 0.
  - in_ready = 1 (combinational from the state).
- Latency, counting edges after the accept edge:
  - out_valid rises after exactly WIDTH edges.
  - For a zero divisor, it rises after 1 edge.
- Return to IDLE: the out handshake edge returns to IDLE, so in_ready = 1 in the following cycle.
  - Minimum initiation interval is WIDTH+2 cycles when out_ready is held high.
- Backpressure: out_valid stays high and the outputs stay bit-stable until out_ready is seen. in_ready stays 0 throughout.
- Output ports change only on the final-iteration edge and on reset.
- Reset asserted mid-RUN or mid-DONE aborts the division immediately. No partial result appears.
- The counter must not wrap: the transition to DONE is decided on count == WIDTH−1.

## Configuration
- Macro DIV_SIGNED_EN.
- Undefined: all operands and results are unsigned, as above.
- Defined: operands and results are two's complement.
  - Operand magnitudes are divided by the same unsigned core.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend (truncation toward zero).
  - The sign fix is folded into the final-iteration load, so latency is unchanged.
  - −2^(WIDTH−1) / −1 gives quotient = −2^(WIDTH−1) (wraps) and remainder = 0.
  - Divide by zero still gives quotient = all ones (−1), remainder = dividend, div_by_zero = 1.

## Test plan
All cases use WIDTH = 8.
- 100 / 7 → quotient = 14, remainder = 2, div_by_zero = 0; out_valid rises exactly 8 edges after the accept edge; in_ready = 0 throughout.
- 5 / 0 → quotient = 0xFF, remainder = 5, div_by_zero = 1; out_valid rises 1 edge after accept.
- Edge cases:
  - 255 / 1 → quotient = 255, remainder = 0.
  - 3 / 200 → quotient = 0, remainder = 3.
  - 200 / 200 → quotient = 1, remainder = 0.
  - Results are delivered back-to-back with out_ready high; the initiation interval is 10 cycles.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE and pulse in_valid with new operands. Required: outputs are stable, in_ready = 0, the pulsed operands are dropped, and the next accepted division is correct.
- Reset: assert rst_n = 0 after 4 RUN iterations. Required: out_valid = 0 and the outputs are 0 immediately, in_ready = 1 after release, and a following 100 / 7 division is correct.
- With DIV_SIGNED_EN defined:
  - −100 / 7 → quotient = 0xF2 (−14), remainder = 0xFE (−2).
  - 100 / −7 → quotient = 0xF2, remainder = 2.
  - −128 / −1 → quotient = 0x80, remainder = 0.
